// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue sequencer for the 8-bit multi-cycle ALU
//
// Purpose: queues ALU requests, issues them one at a time while holding the
// operands stable, and returns each result through a valid/ready response register.
// A NOP is answered locally without starting the ALU. A watchdog turns a missing
// alu_done into an error response.
//
// Ports:
//   clk, reset                       clock; synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op             operands and opcode of the offered command
//   rsp_valid/rsp_ready              response handshake
//   rsp_result, rsp_op, rsp_err      captured result, its opcode, watchdog flag
//   alu_start, alu_a, alu_b, alu_op  ALU request (start is a one-cycle pulse)
//   alu_result, alu_done             ALU completion (combinational, one cycle)
//   busy                             FIFO non-empty or a command in flight

module alu_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        rsp_err,
   output logic        alu_start,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   input  logic [15:0] alu_result,
   input  logic        alu_done,
   output logic        busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [7:0]    fifo_a  [DEPTH];
   logic [7:0]    fifo_b  [DEPTH];
   logic [2:0]    fifo_op [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [WW-1:0] wdog;
   logic          push, pop, head_nop, wdog_expired;

   assign cmd_ready    = (count != CW'(DEPTH));
   assign push         = cmd_valid && cmd_ready;
   // Pops only happen in IDLE, so a response sitting in RESP blocks the queue.
   assign pop          = (state == S_IDLE) && (count != '0);
   assign head_nop     = (fifo_op[rd_ptr] == 3'b000);
   assign wdog_expired = (wdog == WW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      alu_start = 1'b0;
      rsp_valid = 1'b0;
      busy      = (count != '0) || (state != S_IDLE);
      case (state)
         S_IDLE: begin
            // The ALU never raises done for op 000, so a NOP skips straight to RESP.
            if (pop) begin
               state_nx = head_nop ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            alu_start = 1'b1;
            state_nx  = S_WAIT;
         end
         S_WAIT: begin
            if (alu_done || wdog_expired) begin
               state_nx = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // FIFO storage carries no reset; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a[wr_ptr]  <= cmd_a;
         fifo_b[wr_ptr]  <= cmd_b;
         fifo_op[wr_ptr] <= cmd_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wdog       <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         rsp_result <= '0;
         rsp_op     <= '0;
         rsp_err    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         // Operands change only here; the ALU works from these live values
         // from ISSUE through RESP.
         if (pop) begin
            rd_ptr     <= rd_ptr + PW'(1);
            alu_a      <= fifo_a[rd_ptr];
            alu_b      <= fifo_b[rd_ptr];
            alu_op     <= fifo_op[rd_ptr];
            rsp_op     <= fifo_op[rd_ptr];
            rsp_result <= '0;
            rsp_err    <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (state == S_ISSUE) begin
            wdog <= '0;
         end else if (state == S_WAIT) begin
            wdog <= wdog + WW'(1);
            // done wins over an expiring watchdog in the same cycle
            if (alu_done) begin
               rsp_result <= alu_result;
               rsp_err    <= 1'b0;
            end else if (wdog_expired) begin
               rsp_result <= '0;
               rsp_err    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer with a behavioural ALU

module tb_alu_cmd_sequencer;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a, cmd_b;
   logic [2:0]  cmd_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic        rsp_err;
   logic        alu_start;
   logic [7:0]  alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_result;
   logic        alu_done;
   logic        busy;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
      .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_done(alu_done), .busy(busy)
   );

   // Behavioural ALU: done one cycle after start, three cycles later for MUL.
   logic kill_done;
   logic alu_pend;
   int   alu_rem;

   always @(posedge clk) begin
      if (reset) begin
         alu_pend <= 1'b0;
         alu_rem  <= 0;
      end else if (alu_start) begin
         alu_pend <= 1'b1;
         alu_rem  <= (alu_op == 3'b100) ? 3 : 0;
      end else if (alu_pend) begin
         if (alu_rem == 0) alu_pend <= 1'b0;
         else              alu_rem  <= alu_rem - 1;
      end
   end

   assign alu_done = alu_pend && (alu_rem == 0) && !kill_done;

   function automatic logic [15:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
      case (op)
         3'b001:  return {8'h00, a} + {8'h00, b};
         3'b010:  return {8'h00, a & b};
         3'b011:  return {8'h00, a ^ b};
         3'b100:  return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   always_comb alu_result = ref_result(alu_a, alu_b, alu_op);

   int checks = 0;
   int fails  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] res;
      logic        err;
   } exp_t;

   exp_t sb_q[$];

   // Response monitor: pops the scoreboard on every handshake and checks that a
   // stalled response holds its payload.
   logic        hold_v = 1'b0;
   logic [15:0] hold_res;
   logic [2:0]  hold_op;
   logic        hold_err;
   logic        prev_start = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         hold_v     = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (alu_start) check_eq("start_gap", prev_start, 0);
         prev_start = alu_start;
         if (rsp_valid && hold_v) begin
            check_eq("hold_result", rsp_result, hold_res);
            check_eq("hold_op", rsp_op, hold_op);
            check_eq("hold_err", rsp_err, hold_err);
         end
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_nonempty", 32'(sb_q.size()), 1);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_eq("rsp_op", rsp_op, e.op);
               check_eq("rsp_result", rsp_result, e.res);
               check_eq("rsp_err", rsp_err, e.err);
            end
            hold_v = 1'b0;
         end else begin
            hold_v = rsp_valid;
         end
         hold_res = rsp_result;
         hold_op  = rsp_op;
         hold_err = rsp_err;
      end
   end

   // Called just after a rising edge; returns just after the edge that took the command.
   task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [15:0] res);
      bit   ok;
      exp_t e;
      ok        = 1'b0;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok    = 1'b1;
            e.op  = op;
            e.res = kill_done ? 16'h0000 : res;
            e.err = kill_done;
            sb_q.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      check_eq("push_accept", ok, 1);
   endtask

   task automatic wait_idle(input string tag);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 300 && !idle; i++) begin
         @(posedge clk);
         #1;
         if (!busy && !rsp_valid) idle = 1'b1;
      end
      check_eq({tag, "_idle"}, idle, 1);
   endtask

   task automatic run_timed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op, input logic [15:0] res,
                            input int exp_start, input int exp_rsp);
      int first_start, first_rsp;
      push_cmd(a, b, op, res);
      cmd_valid   = 1'b0;
      first_start = -1;
      first_rsp   = -1;
      for (int c = 1; c <= TIMEOUT + 10 && first_rsp < 0; c++) begin
         @(negedge clk);
         if (alu_start && first_start < 0) first_start = c;
         if (rsp_valid) first_rsp = c;
      end
      check_eq({tag, "_start_cycle"}, first_start, exp_start);
      check_eq({tag, "_rsp_cycle"}, first_rsp, exp_rsp);
      wait_idle(tag);
   endtask

   initial begin
      #200000;
      fails++;
      $display("FAIL global_time_limit: got expired expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = '0;
      rsp_ready = 1'b0;
      kill_done = 1'b0;

      // Two reset cycles, then every output 0 except cmd_ready.
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_cmd_ready", cmd_ready, 1);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_result", rsp_result, 0);
      check_eq("rst_rsp_op", rsp_op, 0);
      check_eq("rst_rsp_err", rsp_err, 0);
      check_eq("rst_alu_start", alu_start, 0);
      check_eq("rst_alu_a", alu_a, 0);
      check_eq("rst_alu_b", alu_b, 0);
      check_eq("rst_alu_op", alu_op, 0);
      check_eq("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;

      // Latency of each command class from an idle, empty sequencer.
      run_timed("add", 8'hFF, 8'h01, 3'b001, 16'h0100, 2, 4);
      run_timed("mul", 8'h0C, 8'h0B, 3'b100, 16'h0084, 2, 7);
      run_timed("nop", 8'h12, 8'h34, 3'b000, 16'h0000, -1, 2);
      run_timed("rsvd", 8'h05, 8'h06, 3'b110, 16'h0000, 2, 4);

      // MUL held under backpressure for five cycles.
      begin
         bit seen;
         seen      = 1'b0;
         rsp_ready = 1'b0;
         push_cmd(8'hFF, 8'hFF, 3'b100, 16'hFE01);
         cmd_valid = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
         end
         check_eq("mul_bp_seen", seen, 1);
         repeat (5) begin
            @(negedge clk);
            check_eq("mul_bp_valid", rsp_valid, 1);
            check_eq("mul_bp_result", rsp_result, 16'hFE01);
         end
         @(posedge clk);
         #1;
         rsp_ready = 1'b1;
         @(negedge clk);
         @(negedge clk);
         check_eq("mul_bp_drop", rsp_valid, 0);
         wait_idle("mul_bp");
      end

      // Fill the FIFO behind a stalled response, then drain with wrapping pointers.
      begin
         logic [7:0] a, b;
         logic [2:0] op;
         rsp_ready = 1'b0;
         for (int i = 0; i <= DEPTH; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 3'((i % 3) + 1);
            push_cmd(a, b, op, ref_result(a, b, op));
         end
         cmd_valid = 1'b0;
         @(negedge clk);
         check_eq("full_ready", cmd_ready, 0);
         check_eq("full_busy", busy, 1);
         @(posedge clk);
         #1;
         a  = 8'hA5;
         b  = 8'h3C;
         op = 3'b011;
         fork
            push_cmd(a, b, op, 16'h0099);
            begin
               repeat (3) begin
                  @(negedge clk);
                  check_eq("full_hold_ready", cmd_ready, 0);
               end
               @(posedge clk);
               #1;
               rsp_ready = 1'b1;
            end
         join
         for (int i = 0; i < 2 * DEPTH; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 3'(((i + 1) % 3) + 1);
            push_cmd(a, b, op, ref_result(a, b, op));
         end
         cmd_valid = 1'b0;
         wait_idle("wrap");
         check_eq("wrap_sb_drained", 32'(sb_q.size()), 0);
      end

      // Watchdog: done suppressed, then a normal command afterwards.
      kill_done = 1'b1;
      run_timed("wdog", 8'h01, 8'h02, 3'b001, 16'h0003, 2, TIMEOUT + 4);
      kill_done = 1'b0;
      run_timed("post_wdog", 8'h10, 8'h22, 3'b010, 16'h0000, 2, 4);
      run_timed("xor", 8'hF0, 8'h3C, 3'b011, 16'h00CC, 2, 4);

      // Reset while a MUL is in WAIT: no response ever appears.
      begin
         bit rose;
         push_cmd(8'h07, 8'h09, 3'b100, 16'h003F);
         cmd_valid = 1'b0;
         repeat (3) @(negedge clk);
         @(posedge clk);
         #1;
         reset = 1'b1;
         @(posedge clk);
         #1;
         reset = 1'b0;
         sb_q.delete();
         @(negedge clk);
         check_eq("midrst_busy", busy, 0);
         check_eq("midrst_cmd_ready", cmd_ready, 1);
         rose = 1'b0;
         repeat (10) begin
            @(negedge clk);
            if (rsp_valid) rose = 1'b1;
         end
         check_eq("midrst_no_rsp", rose, 0);
         @(posedge clk);
         #1;
      end

      run_timed("post_rst", 8'h80, 8'h80, 3'b001, 16'h0100, 2, 4);
      check_eq("final_sb_drained", 32'(sb_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
